// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param.
// The producer/consumer side uses master; the FIFO uses slave.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty,
    input  almost_full, almost_empty, count,
    input  overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty,
    output almost_full, almost_empty, count,
    output overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic clk,
  input  logic rst,
  sync_fifo_param_if.slave io_bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_AF    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] LP_AE    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_PINC = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf;
  logic              r_udf;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_full   = (r_count == LP_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_rd_acc = io_bus.rd_en & ~w_empty;
  assign w_wr_acc = io_bus.wr_en & (~w_full | w_rd_acc);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc)
      r_mem[r_wr_ptr] <= io_bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + LP_PINC;
      if (w_rd_acc)
        r_rd_ptr <= r_rd_ptr + LP_PINC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      unique case (1'b1)
        (w_wr_acc & ~w_rd_acc): r_count <= r_count + LP_ONE;
        (w_rd_acc & ~w_wr_acc): r_count <= r_count - LP_ONE;
        default:                r_count <= r_count;
      endcase
    end
  end

  // clr_err wins over a same-cycle error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (io_bus.clr_err) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (io_bus.wr_en & ~w_wr_acc)
        r_ovf <= 1'b1;
      if (io_bus.rd_en & w_empty)
        r_udf <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign io_bus.rd_data  = r_mem[r_rd_ptr];
  assign io_bus.rd_valid = ~w_empty;
`else
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc)
        r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  assign io_bus.rd_data  = r_rd_data;
  assign io_bus.rd_valid = r_rd_valid;
`endif

  assign io_bus.full         = w_full;
  assign io_bus.empty        = w_empty;
  assign io_bus.almost_full  = (r_count >= LP_AF);
  assign io_bus.almost_empty = (r_count <= LP_AE);
  assign io_bus.count        = r_count;
  assign io_bus.overflow     = r_ovf;
  assign io_bus.underflow    = r_udf;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (default 8x8 config).
// Table vectors plus hand sequences for wrap and reset.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  sync_fifo_param #(
    .DATA_W(8), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus)
  );

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       clr;
    int         cnt;
    logic       rv;
    logic [7:0] rdat;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic wr, logic [7:0] wd, logic rd, logic clr,
    int cnt, logic rv, logic [7:0] rdat,
    logic ovf, logic udf
  );
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.clr = clr;
    v.cnt = cnt; v.rv = rv; v.rdat = rdat;
    v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic chk_status(string nm, int cnt);
    chk({nm, " count"}, 32'(bus.count), 32'(cnt));
    chk({nm, " full"}, 32'(bus.full), 32'(cnt == 8));
    chk({nm, " empty"}, 32'(bus.empty), 32'(cnt == 0));
    chk({nm, " afull"}, 32'(bus.almost_full), 32'(cnt >= 6));
    chk({nm, " aempty"}, 32'(bus.almost_empty), 32'(cnt <= 2));
  endtask

  task automatic drive(logic wr, logic [7:0] wd, logic rd, logic clr);
    @(negedge clk);
    bus.wr_en   = wr;
    bus.wr_data = wd;
    bus.rd_en   = rd;
    bus.clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    string nm;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;

    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1, 8'((k+1)*17), 0, 0, k+1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'h99, 0, 0, 8, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 8'hAA, 1, 0, 8, 1, 8'h11, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 8, 0, 8'h11, 0, 0));
    for (int k = 1; k < 8; k++)
      tbl.push_back(mk(0, 8'h00, 1, 0, 8-k, 1, 8'((k+1)*17), 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 8'hAA, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'hAA, 0, 0));
    tbl.push_back(mk(1, 8'h5C, 1, 0, 1, 0, 8'hAA, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 8'h5C, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h5C, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h5C, 0, 0));

    #2;
    chk_status("rst", 0);
    chk("rst rd_valid", 32'(bus.rd_valid), 32'(0));
    chk("rst ovf", 32'(bus.overflow), 32'(0));
    chk("rst udf", 32'(bus.underflow), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].clr);
      nm = $sformatf("v%0d", i);
      chk_status(nm, tbl[i].cnt);
      chk({nm, " ovf"}, 32'(bus.overflow), 32'(tbl[i].ovf));
      chk({nm, " udf"}, 32'(bus.underflow), 32'(tbl[i].udf));
`ifndef SYNC_FIFO_FWFT_EN
      chk({nm, " rd_valid"}, 32'(bus.rd_valid), 32'(tbl[i].rv));
      chk({nm, " rd_data"}, 32'(bus.rd_data), 32'(tbl[i].rdat));
`endif
    end
    idle_inputs();

    // Write/read pairs walking both pointers around several times.
    for (int i = 0; i < 20; i++) begin
      d = 8'(i*7 + 3);
      drive(1, d, 0, 0);
      nm = $sformatf("wrap%0d", i);
      chk({nm, " wcount"}, 32'(bus.count), 32'(1));
`ifdef SYNC_FIFO_FWFT_EN
      chk({nm, " data"}, 32'(bus.rd_data), 32'(d));
`endif
      drive(0, 8'h00, 1, 0);
      chk({nm, " rcount"}, 32'(bus.count), 32'(0));
`ifndef SYNC_FIFO_FWFT_EN
      chk({nm, " rv"}, 32'(bus.rd_valid), 32'(1));
      chk({nm, " data"}, 32'(bus.rd_data), 32'(d));
`endif
    end
    idle_inputs();

    // Mid-stream reset: flush data and sticky flags.
    drive(0, 8'h00, 1, 0);
    chk("pre udf", 32'(bus.underflow), 32'(1));
    for (int k = 0; k < 5; k++)
      drive(1, 8'(k + 1), 0, 0);
    chk("pre count", 32'(bus.count), 32'(5));
    drive(0, 8'h00, 1, 0);
    chk("pre rv", 32'(bus.rd_valid), 32'(1));
    idle_inputs();
    rst = 1'b1;
    #1;
    chk_status("mrst", 0);
    chk("mrst rd_valid", 32'(bus.rd_valid), 32'(0));
    chk("mrst ovf", 32'(bus.overflow), 32'(0));
    chk("mrst udf", 32'(bus.underflow), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    drive(0, 8'h00, 1, 0);
    chk("post udf", 32'(bus.underflow), 32'(1));
    chk("post rv", 32'(bus.rd_valid), 32'(0));
    chk("post count", 32'(bus.count), 32'(0));
    drive(0, 8'h00, 0, 1);
    chk("post clr", 32'(bus.underflow), 32'(0));

`ifdef SYNC_FIFO_FWFT_EN
    drive(1, 8'h11, 0, 0);
    chk("fwft data", 32'(bus.rd_data), 32'h11);
    chk("fwft rv", 32'(bus.rd_valid), 32'(1));
    drive(0, 8'h00, 1, 0);
    chk("fwft pop rv", 32'(bus.rd_valid), 32'(0));
`endif
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised synchronous FIFO. Generalises the fixed 8x8 buffer: configurable data width and depth, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags.
- Sits between producer and consumer datapaths in the same clock domain.
- Storage, pointer control and status logic live in one block.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 3, pointer width; depth DEPTH = 2**ADDR_W.
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL (legal range 1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (legal range 0..DEPTH-1).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, reset; asynchronous, active-high.
- wr_en, input, 1, write request.
- wr_data, input, DATA_W, write data.
- rd_en, input, 1, read request.
- rd_data, output, DATA_W, read data.
- rd_valid, output, 1, rd_data holds a valid popped word.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- almost_full, output, 1, count >= AF_LEVEL.
- almost_empty, output, 1, count <= AE_LEVEL.
- count, output, ADDR_W+1, current occupancy, 0..DEPTH.
- overflow, output, 1, sticky: a write was rejected.
- underflow, output, 1, sticky: a read was rejected.
- clr_err, input, 1, synchronous clear of overflow and underflow.

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock. While rst is high:
  - wr_ptr, rd_ptr, count = 0; rd_data = 0; rd_valid = 0; overflow = underflow = 0.
  - Therefore empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0, never true for legal values) = 0.
  - Memory contents are not reset.
- Reset mid-operation: all stored data is discarded. The first cycle after release behaves as a fresh empty FIFO.
- Status outputs: full, empty, almost_full and almost_empty are combinational decodes of the registered count. They have no extra latency.
- Accept rules, evaluated on the pre-edge state:
  - wr_acc = wr_en & (!full | rd_acc).
  - rd_acc = rd_en & !empty.
- Accepted write: mem[wr_ptr] <= wr_data; wr_ptr increments modulo DEPTH (natural wrap of ADDR_W bits).
- Accepted read: rd_data <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
- rd_valid timing: rd_valid <= rd_acc. Read latency is 1 cycle; rd_data holds its value until the next accepted read.
- count update:
  - +1 on write-only.
  - -1 on read-only.
  - Unchanged when both are accepted or neither is.
- Full + write + read: both are accepted. The read returns the oldest word; the write lands in the freed slot. count stays at DEPTH.
- Empty + write + read: the write is accepted and the read is rejected (no bypass). count goes to 1, rd_valid goes to 0, underflow is set.
- Rejected write (wr_en & !wr_acc): memory and pointers unchanged; overflow <= 1.
- Rejected read (rd_en & empty): pointers and rd_data unchanged; underflow <= 1.
- Error flags:
  - overflow and underflow stay set until clr_err or rst.
  - clr_err has priority over setting in the same cycle.
- Wrap-around: pointers wrap silently. full/empty are derived from count only, never from pointer equality.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rd_data = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en acts as a pop acknowledge: on rd_acc, rd_ptr advances and the next word appears in the same cycle after the edge.
  - Read latency is 0. Underflow rules are unchanged.
- Undefined: standard mode as specified above (registered rd_data, 1-cycle latency).

Test Plan (defaults: DATA_W=8, ADDR_W=3, AF_LEVEL=6, AE_LEVEL=2):
- Reset with rst high mid-stream after 5 writes -> count = 0, empty = 1, rd_valid = 0, flags = 0. Next read sets underflow = 1.
- Write 0x11..0x88 (8 words), then read 8 -> full = 1 after the 8th write. rd_data sequence is 0x11..0x88, each with rd_valid one cycle after its rd_en. empty = 1 at the end.
- Fill to 8, then write 0x99 alone -> rejected, overflow = 1, count = 8. Subsequent reads never return 0x99. clr_err -> overflow = 0.
- Full, then simultaneous wr_en (0xAA) and rd_en -> rd_data = oldest word, count stays 8. 0xAA is returned last.
- Empty, then simultaneous wr_en (0x5C) and rd_en -> count = 1, rd_valid = 0, underflow = 1. The next read returns 0x5C.
- Threshold sweep: write one word at a time -> almost_empty true for counts 0..2; almost_full true from count 6. 20 write/read pairs across pointer wrap preserve order. In FWFT build, 0x11 is visible on rd_data the cycle after the first write.
